// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcode/funct encodings, fetch sequencer
// states and a small saturating-counter helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000011;
  localparam logic [5:0] OP_J     = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;

  localparam logic [5:0] FUNCT_AND = 6'b000000;
  localparam logic [5:0] FUNCT_OR  = 6'b000001;
  localparam logic [5:0] FUNCT_ADD = 6'b000010;
  localparam logic [5:0] FUNCT_SUB = 6'b000110;
  localparam logic [5:0] FUNCT_SLT = 6'b000111;
  localparam logic [5:0] FUNCT_NOR = 6'b001100;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Loader, instruction-memory and decode-side signals of the fetch controller.
// The controller takes the slave view; its environment takes the master view.
interface imem_fetch_ctrl_if;
  logic        start;
  logic        halt;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ins;
  logic [15:0] fetch_count;

  modport master (
    output start, halt, ld_valid, ld_addr, ld_data, stall,
           redirect_valid, redirect_pc, mem_rdata,
    input  ld_ready, mem_addr, mem_we, mem_wdata,
           if_valid, if_pc, if_ins, fetch_count
  );

  modport slave (
    input  start, halt, ld_valid, ld_addr, ld_data, stall,
           redirect_valid, redirect_pc, mem_rdata,
    output ld_ready, mem_addr, mem_we, mem_wdata,
           if_valid, if_pc, if_ins, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: the loader owns the memory until start, then
// the fetch path drives the PC and fills the IF/ID register (stall/redirect/halt).
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  imem_fetch_ctrl_if.slave bus
);

  // PC lives modulo the memory size in bytes; DEPTH is a power of two.
  localparam logic [31:0] PC_MASK  = 32'(DEPTH * 4) - 32'd1;
  localparam logic [31:0] PC_RESET = RESET_PC & PC_MASK;

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_if_valid, w_if_valid_nxt;
  logic [31:0]  r_if_pc, w_if_pc_nxt;
  logic [31:0]  r_if_ins, w_if_ins_nxt;
  logic [15:0]  r_fetch_count, w_fetch_count_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= LOAD;
      r_pc          <= PC_RESET;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_ins      <= '0;
      r_fetch_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_ins      <= w_if_ins_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_valid_nxt    = r_if_valid;
    w_if_pc_nxt       = r_if_pc;
    w_if_ins_nxt      = r_if_ins;
    w_fetch_count_nxt = r_fetch_count;
    bus.ld_ready      = 1'b0;
    bus.mem_addr      = r_pc;
    bus.mem_we        = 1'b0;
    bus.mem_wdata     = bus.ld_data;

    unique case (r_state)
      LOAD: begin
        bus.ld_ready = 1'b1;
        bus.mem_addr = bus.ld_addr;
        bus.mem_we   = bus.ld_valid;
        if (bus.start) w_state_nxt = FETCH;
      end

      FETCH: begin
        if (bus.redirect_valid) begin
          // A redirect flushes IF/ID even under stall; a simultaneous halt still halts.
          w_pc_nxt       = bus.redirect_pc & PC_MASK & ~32'd3;
          w_if_valid_nxt = 1'b0;
          if (bus.halt) w_state_nxt = HALT;
        end else if (bus.halt) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = HALT;
        end else if (!bus.stall) begin
          w_if_ins_nxt      = bus.mem_rdata;
          w_if_pc_nxt       = r_pc;
          w_if_valid_nxt    = 1'b1;
          w_pc_nxt          = (r_pc + WORD_BYTES) & PC_MASK;
          w_fetch_count_nxt = sat_inc16(r_fetch_count);
        end
      end

      HALT: begin
        w_if_valid_nxt = 1'b0;
        if (bus.start) w_state_nxt = FETCH;
      end

      default: w_state_nxt = LOAD;
    endcase
  end

  assign bus.if_valid    = r_if_valid;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_ins      = r_if_ins;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and access arbiter for the single-port instruction memory. After reset it owns the memory on behalf of a loader, which writes the program word by word. On `start` it hands the memory to the fetch path, which drives the PC, fills the IF/ID register, and honours stall, redirect (branch/jump) and halt from the core. It sits between the loader, a writable instruction memory (`imem_rw`, asynchronous read) and the decode stage.

## Interface
- `DEPTH`, 32: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 0: byte address fetched first; word-aligned.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  LOAD/HALT → FETCH.
- `halt`  in  1  FETCH → HALT.
- `ld_valid`  in  1  loader write request.
- `ld_addr`  in  32  loader byte address.
- `ld_data`  in  32  loader write data.
- `ld_ready`  out  1  loader may write (state == LOAD).
- `stall`  in  1  decode not accepting; freeze fetch.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_pc`  in  32  target byte address.
- `mem_addr`  out  32  memory byte address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, combinational from `mem_addr`.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_pc`  out  32  PC of `if_ins`.
- `if_ins`  out  32  fetched instruction.
- `fetch_count`  out  16  instructions fetched since reset; saturates at 16'hFFFF.

## Operation
- States: LOAD (reset state), FETCH, HALT.
- LOAD:
  - `ld_ready`=1.
  - `mem_addr`=`ld_addr`, `mem_we`=`ld_valid`, `mem_wdata`=`ld_data`.
  - `halt`, `stall` and `redirect_valid` are ignored.
  - `start` → FETCH. If `ld_valid` is also high in the same cycle, that write completes.
- FETCH:
  - `mem_addr`=`pc`, `mem_we`=0, `ld_ready`=0. `ld_valid` is ignored (no write).
  - Priority each cycle: redirect > halt > stall > advance.
  - Redirect: `pc`←{`redirect_pc`[31:2],2'b00}, `if_valid`←0 (flush). This applies even when `stall`=1.
  - Halt: `if_valid`←0, `pc` holds, state → HALT. Halt together with redirect loads `pc` from the redirect target, then halts.
  - Stall: `pc`, `if_*` and `fetch_count` hold.
  - Advance: `if_ins`←`mem_rdata`, `if_pc`←`pc`, `if_valid`←1, `pc`←`pc`+4, `fetch_count`+1 (saturating).
- HALT:
  - `if_valid`=0, `pc` holds, memory idle (`mem_we`=0).
  - `start` → FETCH, resuming at the held `pc`. `redirect_valid` is ignored.
  - LOAD is re-entered only through `rst`.
- PC wrap: `pc` is kept modulo DEPTH*4. Advancing from (DEPTH-1)*4 gives 0. Redirect targets are also reduced modulo DEPTH*4.
- Loader addresses are word-indexed by the memory as `ld_addr`>>2; no range check in this block.

## Timing
- Reset (async, `rst`=0) values:
  - State LOAD; `ld_ready`=1; `mem_we`=0.
  - `pc`=`RESET_PC`.
  - `if_valid`=0, `if_pc`=0, `if_ins`=0, `fetch_count`=0.
- `mem_addr`, `mem_we`, `mem_wdata` and `ld_ready` are combinational from state and inputs. All other outputs are registered.
- Fetch latency: the instruction at `pc` appears on `if_ins` with `if_valid`=1 one cycle after the advancing edge.
- First fetch: edge N samples `start`=1; edge N+1 captures the instruction at `RESET_PC`.
- Redirect: one bubble (`if_valid`=0) on the cycle after the redirect edge. The target instruction is valid on the following edge.
- Reset mid-operation: all registers return to reset values immediately. Memory contents are not touched.

## Structure
- Shared package `mips_pkg`:
  - Opcode constants: R-type 000000, lw 000001, sw 000010, beq 000011, j 000100, addi 001000, subi 001001.
  - Funct constants: AND 000000, OR 000001, ADD 000010, SUB 000110, SLT 000111, NOR 001100.
  - `fetch_state_t` enum {LOAD, FETCH, HALT}.
- Sub-modules: none inside this block. `imem_rw` (writable, async-read memory) is a separate sibling instantiated next to it.

## Test plan
- Load then run: write 32'h0088_5002 @0 and 32'h2040_0004 @4, pulse `start`. Required: `if_ins` = 32'h0088_5002 (pc 0), then 32'h2040_0004 (pc 4) on consecutive cycles; `fetch_count`=2.
- Stall: `stall`=1 for 3 cycles at pc 8. Required: `if_pc`, `if_ins` and `fetch_count` frozen; fetch resumes at pc 8.
- Redirect priority: `redirect_valid`=1 with `redirect_pc`=32'h0000_0013 while `stall`=1. Required: next cycle `if_valid`=0; following cycle `if_pc`=16.
- Wrap: run from pc 124 (DEPTH=32). Required: the next `if_pc` is 0.
- Halt/resume: `halt` at pc 20, then `start` 4 cycles later. Required: `if_valid`=0 throughout HALT; next valid `if_pc`=20; `ld_valid` during HALT/FETCH causes no `mem_we`.
- Async reset during FETCH at pc 40. Required: outputs immediately return to reset values; `ld_ready`=1; after `start`, the first `if_pc` is `RESET_PC`.
